// File: rtl/shift_wb.sv
// Write-back stage for the shift/ALU pipeline: one pending result slot that
// commits a cycle after acceptance, with a bypass on the register read port.
module shift_wb #(
    parameter int NREG = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [2:0]  in_rd,
    input  logic [15:0] in_result,
    input  logic [3:0]  in_szcv,
    input  logic [2:0]  rd_addr,
    output logic [15:0] rd_data,
    output logic [3:0]  flags,
    output logic [15:0] out_port,
    output logic        halted
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam logic [3:0] OP_OUT = 4'b1101;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Ops whose result lands in the register file (CMP, 0111, OUT, 1110, HLT do not).
    function automatic logic writes_reg(input logic [3:0] op);
        return (op <= 4'b0100) || (op == 4'b0110) || (op >= 4'b1000 && op <= 4'b1100);
    endfunction

    function automatic logic writes_flags(input logic [3:0] op);
        return (op <= 4'b0110) || (op >= 4'b1000 && op <= 4'b1011);
    endfunction

    state_t      state_q, state_d;
    logic        p_valid_q, p_valid_d;
    logic [3:0]  p_op_q, p_op_d;
    logic [2:0]  p_rd_q, p_rd_d;
    logic [15:0] p_result_q, p_result_d;
    logic [3:0]  p_szcv_q, p_szcv_d;
    logic [3:0]  flags_q, flags_d;
    logic [15:0] out_port_q, out_port_d;
    logic [15:0] regs_q [NREG];

    logic accept;
    logic commit_wr;

    assign in_ready  = (state_q == RUN);
    assign halted    = (state_q == HALT);
    assign accept    = in_valid && in_ready;
    assign commit_wr = p_valid_q && writes_reg(p_op_q);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        state_d    = state_q;
        p_valid_d  = accept;
        p_op_d     = p_op_q;
        p_rd_d     = p_rd_q;
        p_result_d = p_result_q;
        p_szcv_d   = p_szcv_q;
        flags_d    = flags_q;
        out_port_d = out_port_q;

        // Payload is only captured on acceptance, so idle-cycle X never enters the slot.
        if (accept) begin
            p_op_d     = in_op;
            p_rd_d     = in_rd;
            p_result_d = in_result;
            p_szcv_d   = in_szcv;
            if (in_op == OP_HLT) begin
                state_d = HALT;
            end
        end

        if (p_valid_q) begin
            if (writes_flags(p_op_q)) begin
                flags_d = p_szcv_q;
            end
            if (p_op_q == OP_OUT) begin
                out_port_d = p_result_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q    <= RUN;
            p_valid_q  <= 1'b0;
            p_op_q     <= '0;
            p_rd_q     <= '0;
            p_result_q <= '0;
            p_szcv_q   <= '0;
            flags_q    <= '0;
            out_port_q <= '0;
            // NOTE: the register file must read zero after reset, so it is built from resettable flops rather than RAM.
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            p_valid_q  <= p_valid_d;
            p_op_q     <= p_op_d;
            p_rd_q     <= p_rd_d;
            p_result_q <= p_result_d;
            p_szcv_q   <= p_szcv_d;
            flags_q    <= flags_d;
            out_port_q <= out_port_d;
            if (commit_wr) begin
                regs_q[p_rd_q] <= p_result_q;
            end
        end
    end

    // Pending writer bypasses the register file so a dependent read sees it a cycle early.
    assign rd_data  = (commit_wr && (p_rd_q == rd_addr)) ? p_result_q : regs_q[rd_addr];
    assign flags    = flags_q;
    assign out_port = out_port_q;

endmodule

// File: tb/tb_shift_wb.sv
// Directed bench for shift_wb: stimulus pushes hand-computed expectations
// tagged with a cycle number; a negedge monitor pops and compares them.
module tb_shift_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [2:0]  in_rd;
    logic [15:0] in_result;
    logic [3:0]  in_szcv;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data;
    logic [3:0]  flags;
    logic [15:0] out_port;
    logic        halted;

    shift_wb #(.NREG(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_result (in_result),
        .in_szcv   (in_szcv),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .flags     (flags),
        .out_port  (out_port),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    typedef enum {K_RD, K_FLAGS, K_OUT, K_HALT, K_READY} kind_e;
    typedef struct {
        int          at;
        kind_e       kind;
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every expectation due in the current cycle.
    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] actual;
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            case (e.kind)
                K_RD:    actual = rd_data;
                K_FLAGS: actual = {12'b0, flags};
                K_OUT:   actual = out_port;
                K_HALT:  actual = {15'b0, halted};
                default: actual = {15'b0, in_ready};
            endcase
            n_tests++;
            if (actual !== e.val || e.at != cyc) begin
                n_fail++;
                $display("FAIL %s @cyc %0d: got %h, expected %h (due cyc %0d)",
                         e.name, cyc, actual, e.val, e.at);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input kind_e k, input logic [15:0] v, input string nm);
        exp_t e;
        e.at   = cyc;
        e.kind = k;
        e.val  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic chk_rd(input logic [2:0] a, input logic [15:0] v, input string nm);
        rd_addr = a;
        chk(K_RD, v, nm);
    endtask

    task automatic drive(input logic [3:0] op, input logic [2:0] rd,
                         input logic [15:0] res, input logic [3:0] f);
        in_valid  = 1'b1;
        in_op     = op;
        in_rd     = rd;
        in_result = res;
        in_szcv   = f;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        in_op     = 'x;
        in_rd     = 'x;
        in_result = 'x;
        in_szcv   = 'x;
    endtask

    task automatic check_all_zero(input string nm);
        chk(K_FLAGS, 16'h0, {nm, "_flags"});
        chk(K_OUT,   16'h0, {nm, "_out"});
        chk(K_HALT,  16'h0, {nm, "_halted"});
        chk(K_READY, 16'h1, {nm, "_ready"});
        for (int i = 0; i < 8; i++) begin
            chk_rd(3'(i), 16'h0, $sformatf("%s_reg%0d", nm, i));
            tick();
        end
    endtask

    initial begin
        rst     = 1'b1;
        rd_addr = '0;
        idle();
        tick();
        tick();
        rst = 1'b0;
        check_all_zero("reset");

        // SLL rd3 0x8000: bypass visible one cycle after acceptance, committed one later.
        drive(4'b1000, 3'd3, 16'h8000, 4'b1000);
        tick();
        idle();
        chk_rd(3'd3, 16'h8000, "sll_bypass");
        chk(K_FLAGS, 16'h0, "sll_flags_pre");
        tick();
        chk_rd(3'd3, 16'h8000, "sll_reg3");
        chk(K_FLAGS, 16'h8, "sll_flags");
        tick();

        // CMP updates flags only.
        drive(4'b0101, 3'd2, 16'h1234, 4'b0100);
        tick();
        idle();
        chk_rd(3'd2, 16'h0, "cmp_no_bypass");
        tick();
        chk_rd(3'd2, 16'h0, "cmp_reg2");
        chk(K_FLAGS, 16'h4, "cmp_flags");
        tick();

        // Back-to-back SRL then SRA to rd1: later result wins.
        drive(4'b1001, 3'd1, 16'h0001, 4'b0010);
        tick();
        drive(4'b1010, 3'd1, 16'hFFFF, 4'b1000);
        chk_rd(3'd1, 16'h0001, "srl_bypass");
        tick();
        idle();
        chk_rd(3'd1, 16'hFFFF, "sra_bypass");
        chk(K_FLAGS, 16'h2, "srl_flags");
        tick();
        chk_rd(3'd1, 16'hFFFF, "sra_reg1");
        chk(K_FLAGS, 16'h8, "sra_flags");
        tick();

        // OUT loads out_port only.
        drive(4'b1101, 3'd4, 16'h00A5, 4'b0101);
        tick();
        idle();
        chk(K_OUT, 16'h0, "out_pre");
        chk_rd(3'd4, 16'h0, "out_no_bypass");
        tick();
        chk(K_OUT, 16'h00A5, "out_port");
        chk(K_FLAGS, 16'h8, "out_flags_hold");
        chk_rd(3'd4, 16'h0, "out_reg4");
        tick();
        chk_rd(3'd3, 16'h8000, "out_reg3_hold");
        tick();

        // IN writes without flags; op 0111 writes nothing.
        drive(4'b1100, 3'd6, 16'h1357, 4'b1111);
        tick();
        drive(4'b0111, 3'd7, 16'hBEEF, 4'b1111);
        chk_rd(3'd6, 16'h1357, "in_bypass");
        tick();
        idle();
        chk_rd(3'd7, 16'h0, "op7_no_bypass");
        chk(K_FLAGS, 16'h8, "in_flags_hold");
        tick();
        chk_rd(3'd7, 16'h0, "op7_reg7");
        chk(K_FLAGS, 16'h8, "op7_flags_hold");
        tick();
        chk_rd(3'd6, 16'h1357, "in_reg6");
        tick();

        // ADD then HLT back-to-back; inputs ignored while halted.
        drive(4'b0000, 3'd0, 16'h0042, 4'b0001);
        tick();
        drive(4'b1111, 3'd0, 16'h9999, 4'b1111);
        tick();
        drive(4'b0000, 3'd1, 16'h5555, 4'b0110);
        chk(K_HALT, 16'h1, "hlt_halted");
        chk(K_READY, 16'h0, "hlt_ready");
        chk_rd(3'd0, 16'h0042, "add_reg0");
        chk(K_FLAGS, 16'h1, "add_flags");
        tick();
        chk(K_HALT, 16'h1, "halt_persist");
        chk(K_READY, 16'h0, "halt_ready_persist");
        chk_rd(3'd1, 16'hFFFF, "halt_ignore_bypass");
        tick();
        idle();
        chk_rd(3'd1, 16'hFFFF, "halt_ignore_reg1");
        chk(K_FLAGS, 16'h1, "halt_flags_hold");
        tick();

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("halt_reset");

        // Reset discards a pending entry and beats a same-cycle acceptance.
        drive(4'b1001, 3'd5, 16'h00FF, 4'b0000);
        tick();
        rst = 1'b1;
        drive(4'b0000, 3'd2, 16'h7777, 4'b0001);
        tick();
        rst = 1'b0;
        idle();
        chk_rd(3'd2, 16'h0, "rst_no_accept");
        chk(K_FLAGS, 16'h0, "rst_pend_flags");
        tick();
        chk_rd(3'd5, 16'h0, "rst_pend_reg5");
        chk(K_FLAGS, 16'h0, "rst_pend_flags2");
        tick();
        chk_rd(3'd2, 16'h0, "rst_reg2");
        tick();
        tick();

        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
